// File: rtl/bioee_adc_capture.sv
// Capture stage for the external 12-bit parallel ADC: generates the conversion
// clock, samples data at a fixed delay, averages, and feeds the SDRAM FIFO.
module bioee_adc_capture #(
  parameter int unsigned CLK_DIV       = 100,
  parameter int unsigned CAPTURE_DELAY = 2,
  parameter int unsigned AVG_LOG2      = 0,
  parameter int unsigned DISCARD       = 3
) (
  input  logic        clkin,
  input  logic        resetn,
  input  logic        enable,
  input  logic [11:0] adc_data,
  input  logic        adc_otr,
  input  logic        fifo_full,
  output logic        adc_clk,
  output logic [15:0] dataout,
  output logic        write_en,
  output logic        overflow,
  output logic [31:0] sample_count
);

  localparam int unsigned HALF     = CLK_DIV / 2;
  localparam int unsigned WIN_LAST = (1 << AVG_LOG2) - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] acc;
  logic [4:0]  win;
  logic [3:0]  disc;
  logic        otr_acc;
  logic        start_pend;

  logic [15:0] cnt_next;
  logic [15:0] sum;
  logic        capture;
  logic        win_done;

  always_comb begin
    cnt_next = (cnt == 16'(CLK_DIV - 1)) ? '0 : cnt + 16'd1;
    sum      = acc + {4'b0000, adc_data};
    capture  = (cnt == 16'(CAPTURE_DELAY));
    win_done = (win == 5'(WIN_LAST));
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      win          <= '0;
      disc         <= '0;
      otr_acc      <= 1'b0;
      start_pend   <= 1'b0;
      adc_clk      <= 1'b0;
      dataout      <= '0;
      write_en     <= 1'b0;
      overflow     <= 1'b0;
      sample_count <= '0;
    end else begin
      write_en <= 1'b0;
      unique case (state)
        IDLE: begin
          adc_clk <= 1'b0;
          cnt     <= '0;
          if (enable) begin
            // adc_clk is registered, so the first RUN cycle already drives it high
            state      <= RUN;
            adc_clk    <= 1'b1;
            disc       <= 4'(DISCARD);
            start_pend <= 1'b1;
            acc        <= '0;
            win        <= '0;
            otr_acc    <= 1'b0;
            overflow   <= 1'b0;
          end
        end
        RUN: begin
          if (!enable) begin
            state   <= IDLE;
            adc_clk <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt     <= cnt_next;
            adc_clk <= (cnt_next < 16'(HALF));
            if (capture) begin
              if (disc != 4'd0) begin
                disc <= disc - 4'd1;
              end else if (win_done) begin
                dataout <= {start_pend, 2'b00, otr_acc | adc_otr, sum[AVG_LOG2 +: 12]};
                if (!fifo_full) begin
                  write_en     <= 1'b1;
                  start_pend   <= 1'b0;
                  sample_count <= sample_count + 32'd1;
                end else begin
                  overflow <= 1'b1;
                end
                acc     <= '0;
                win     <= '0;
                otr_acc <= 1'b0;
              end else begin
                acc     <= sum;
                win     <= win + 5'd1;
                otr_acc <= otr_acc | adc_otr;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bioee_adc_capture.md
Name: bioee_adc_capture

Overview:
- Upstream capture stage for the external 12-bit parallel ADC on the ybus header.
- Generates the ADC conversion clock from the 100 MHz system clock.
- Samples the ADC data and over-range pins at a programmable delay, with optional power-of-two averaging.
- Emits 16-bit words with a write strobe into the SDRAM FIFO write port, and reports overflow when the FIFO is full.

Parameters:
- CLK_DIV, 100: clkin cycles per ADC conversion; even, 4..65534.
- CAPTURE_DELAY, 2: clkin cycles after the adc_clk rising edge at which pins are sampled; 0..CLK_DIV-1.
- AVG_LOG2, 0: averaging window is 2^AVG_LOG2 conversions; 0..4.
- DISCARD, 3: conversions dropped after each enable rise, to flush the ADC pipeline; 0..15.

Ports:
- clkin, input, 1: system clock, 100 MHz.
- resetn, input, 1: reset; asynchronous, active-low.
- enable, input, 1: run request, level-sensitive, synchronous to clkin.
- adc_data, input, 12: ADC parallel output; bit 11 is MSB, already bit-ordered by the top level.
- adc_otr, input, 1: ADC over-range flag.
- fifo_full, input, 1: FIFO cannot accept a word this cycle.
- adc_clk, output, 1: conversion clock to the ADC pin buffer.
- dataout, output, 16: {start, 2'b00, otr, sample[11:0]}.
- write_en, output, 1: one-cycle strobe; dataout is valid while high.
- overflow, output, 1: sticky, set when a word was dropped because fifo_full was high.
- sample_count, output, 32: number of words accepted by the FIFO.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, cnt=0, acc=0, win=0, disc=0, start_pend=0.
  - All outputs are 0: adc_clk, dataout, write_en, overflow, sample_count.
- State IDLE:
  - adc_clk=0, cnt=0, write_en=0.
  - On a clkin edge with enable=1: go to RUN; load disc=DISCARD, start_pend=1, acc=0, win=0; clear overflow.
- State RUN:
  - cnt increments by 1 each cycle and wraps from CLK_DIV-1 to 0; cnt=0 on the first RUN cycle.
  - adc_clk is registered: 1 while cnt<CLK_DIV/2, else 0. The first RUN cycle therefore drives adc_clk=1.
  - Capture event: the clkin edge at which cnt==CAPTURE_DELAY.
  - At a capture event with disc>0: decrement disc; the sample is ignored.
  - At a capture event with disc==0:
    - s = adc_data zero-extended to 16 bits; sum = acc + s.
    - otr_acc accumulates the OR of adc_otr across the window.
    - If win == 2^AVG_LOG2 - 1 (window complete):
      - dataout <= {start_pend, 2'b00, otr_acc|adc_otr, sum[AVG_LOG2+11:AVG_LOG2]}. This is a truncating divide; no rounding.
      - If fifo_full=0: write_en <= 1, start_pend <= 0, sample_count <= sample_count+1.
      - If fifo_full=1: write_en stays 0, overflow <= 1, start_pend is kept so the next accepted word carries start=1.
      - Then acc <= 0, win <= 0, otr_acc <= 0.
    - Otherwise: acc <= sum, win <= win+1.
  - write_en is high for exactly one cycle, the cycle after the capture edge. At most one strobe per CLK_DIV·2^AVG_LOG2 cycles.
  - fifo_full is sampled only at the completing capture edge; no retry or holding.
  - enable=0 at any clkin edge: go to IDLE next cycle. The partial window is discarded, adc_clk returns to 0 and write_en is 0. overflow and sample_count are held.
  - enable re-asserted: restarts with DISCARD flushing and start=1.
- sample_count wraps from 2^32-1 to 0.
- Reset asserted mid-window or mid-strobe: all outputs go to 0 immediately (asynchronous).
  - After resetn deasserts: the first edge with enable=1 enters RUN as above.
- Latency:
  - Pin to write_en is 1 clkin cycle after the completing capture edge.
  - The first word after an enable rise appears at cycle (DISCARD + 2^AVG_LOG2 - 1)·CLK_DIV + CAPTURE_DELAY + 1 counted from the first RUN cycle.

Test Plan:
- Basic ramp: CLK_DIV=4, CAPTURE_DELAY=1, DISCARD=0, AVG_LOG2=0; adc_data ramps 0,1,2.. once per conversion; fifo_full=0.
  - Required: adc_clk pattern 1100 repeating; write_en every 4 cycles, first at RUN cycle 2.
  - Required: dataout = 0x8000, 0x0001, 0x0002..; sample_count = number of strobes.
- Averaging: AVG_LOG2=2; adc_data = 10, 11, 12, 14; adc_otr high only on the 3rd conversion.
  - Required: one strobe, dataout = 0x9000|11 = 0x900B (start=1, otr=1, sample=11).
- Full-scale average: AVG_LOG2=4, adc_data=0xFFF constantly.
  - Required: dataout[11:0]=0xFFF with no carry into bit 12; 0x8FFF for the first word, then 0x0FFF.
- Overflow: fifo_full=1 during the 2nd completing capture edge only.
  - Required: 2nd word dropped; overflow=1 from then on, sticky; sample_count skips it.
  - Required: next word has start=0 (start was already consumed by word 1).
  - Required: toggling enable 0→1 clears overflow and the next accepted word has bit 15=1.
- Discard: DISCARD=3.
  - Required: no write_en during the first 3 conversions; the 4th conversion's value is emitted with bit 15=1.
- Mid-operation abort:
  - Drop enable halfway through an AVG_LOG2=2 window → adc_clk=0 next cycle, no strobe, partial sum not emitted on restart.
  - Pulse resetn low while write_en=1 → write_en, overflow and sample_count are 0 immediately.
